// File: rtl/nvm_prog_ctrl_if.sv
// nvm_prog_ctrl_if: signal bundle between the byte loader, the NVM array port
// and nvm_prog_ctrl. The "slave" modport is the controller's view; the
// "master" modport is the loader/memory side that issues requests and
// returns read data.
interface nvm_prog_ctrl_if #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int CNT_WIDTH      = 16
);
    logic                      start;
    logic [MEM_ADDR_WIDTH-1:0] base_addr;
    logic [CNT_WIDTH-1:0]      word_cnt;
    logic                      byte_valid;
    logic [7:0]                byte_data;
    logic                      byte_ready;
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_wd;
    logic [MEM_DATA_WIDTH-1:0] mem_rd;
    logic                      busy;
    logic                      done;
    logic                      error;
    logic [MEM_ADDR_WIDTH-1:0] err_addr;

    modport master (
        output start, base_addr, word_cnt, byte_valid, byte_data, mem_rd,
        input  byte_ready, mem_we, mem_addr, mem_wd, busy, done, error, err_addr
    );

    modport slave (
        input  start, base_addr, word_cnt, byte_valid, byte_data, mem_rd,
        output byte_ready, mem_we, mem_addr, mem_wd, busy, done, error, err_addr
    );
endinterface

// File: rtl/nvm_prog_ctrl.sv
// nvm_prog_ctrl: packs a little-endian byte stream into words and writes them
// to consecutive NVM word addresses starting at a captured base address.
// Optional read-back verify is compiled in with `define NVM_PROG_VERIFY_EN.
module nvm_prog_ctrl #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    nvm_prog_ctrl_if.slave bus
);
    localparam int BYTES = MEM_DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE  = CNT_WIDTH'(1);

    // S_VERIFY and S_FAIL are only reachable when verify is compiled in.
    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_VERIFY,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                    r_state;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]      r_remain;
    logic [IDX_W-1:0]          r_idx;
    logic [MEM_DATA_WIDTH-1:0] r_word;

    logic   w_hs;
    state_t w_step_state;

    assign w_hs         = bus.byte_valid && (r_state == S_COLLECT);
    assign w_step_state = (r_remain == CNT_ONE) ? S_DONE : S_COLLECT;

`ifdef NVM_PROG_VERIFY_EN
    logic                      r_error;
    logic [MEM_ADDR_WIDTH-1:0] r_err_addr;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^bus.mem_rd;
`endif

    // Control FSM: capture run parameters, collect bytes, write, verify, step.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch;
        // every state register gets <= so all updates land together at the edge.
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_idx      <= '0;
            r_word     <= '0;
`ifdef NVM_PROG_VERIFY_EN
            r_error    <= 1'b0;
            r_err_addr <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr   <= bus.base_addr;
                        r_remain <= bus.word_cnt;
                        r_idx    <= '0;
                        r_word   <= '0;
`ifdef NVM_PROG_VERIFY_EN
                        r_error    <= 1'b0;
                        r_err_addr <= '0;
`endif
                        r_state  <= (bus.word_cnt == '0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_hs) begin
                        r_word[8*r_idx +: 8] <= bus.byte_data;
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= S_WRITE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
`ifdef NVM_PROG_VERIFY_EN
                S_WRITE: r_state <= S_VERIFY;
                S_VERIFY: begin
                    if (bus.mem_rd != r_word) begin
                        r_error    <= 1'b1;
                        r_err_addr <= r_addr;
                        r_state    <= S_FAIL;
                    end else begin
                        r_remain <= r_remain - CNT_ONE;
                        r_addr   <= r_addr + ADDR_ONE;
                        r_state  <= w_step_state;
                    end
                end
                S_FAIL: r_state <= S_IDLE;
`else
                S_WRITE: begin
                    r_remain <= r_remain - CNT_ONE;
                    r_addr   <= r_addr + ADDR_ONE;
                    r_state  <= w_step_state;
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode directly from the registered state and datapath registers.
    assign bus.byte_ready = (r_state == S_COLLECT);
    assign bus.mem_we     = (r_state == S_WRITE);
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wd     = r_word;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
`ifdef NVM_PROG_VERIFY_EN
    assign bus.error      = r_error;
    assign bus.err_addr   = r_err_addr;
`else
    assign bus.error      = 1'b0;
    assign bus.err_addr   = '0;
`endif
endmodule

// File: tb/tb_nvm_prog_ctrl.sv
// tb_nvm_prog_ctrl: randomized and directed stimulus for nvm_prog_ctrl with a
// behavioural model (expected write list and run length from packed bytes)
// and a simple word-array memory. Works with or without NVM_PROG_VERIFY_EN.
`timescale 1ns/1ps
module tb_nvm_prog_ctrl;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int BYTES = DW / 8;
`ifdef NVM_PROG_VERIFY_EN
    localparam int CYC_PER_WORD = BYTES + 2;
`else
    localparam int CYC_PER_WORD = BYTES + 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nvm_prog_ctrl_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    nvm_prog_ctrl #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: synchronous write, combinational read with optional bit-0 corruption.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          corrupt_en   = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    assign bus.mem_rd = mem[bus.mem_addr] ^
                        ((corrupt_en && bus.mem_addr == corrupt_addr) ? DW'(1) : DW'(0));
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;

    int we_cycles = 0;
    always @(negedge clk) if (bus.mem_we === 1'b1) we_cycles++;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] stim_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One programming run. mode: 0 continuous stream, 1 valid every other cycle, 2 random.
    task automatic run_prog(input logic [AW-1:0] base, input int n, input int mode,
                            input bit expect_fail, input logic [AW-1:0] fail_addr);
        logic [AW-1:0] exp_addr[$];
        logic [DW-1:0] exp_data[$];
        logic [AW-1:0] got_addr[$];
        logic [DW-1:0] got_data[$];
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        int  n_exp, done_cyc, hs, overlap, bi, limit;
        bit  pending, err_seen, valid;

        for (int k = 0; k < n; k++) begin
            w = '0;
            for (int b = 0; b < BYTES; b++) w[8*b +: 8] = stim_q[k*BYTES + b];
            a = base + AW'(k);
            exp_addr.push_back(a);
            exp_data.push_back(w);
        end
        n_exp = n;
        if (expect_fail) begin
            for (int k = n - 1; k >= 0; k--) if (exp_addr[k] == fail_addr) n_exp = k + 1;
        end

        done_cyc = -1; hs = 0; overlap = 0; bi = 0; pending = 0; err_seen = 0; valid = 0;
        limit = 3 * CYC_PER_WORD * n + 20;

        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = base; bus.word_cnt = CW'(n); bus.byte_valid = 1'b0;
        @(negedge clk);
        check("busy_in_start_cycle", bus.busy, 1'b0);

        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (pending) valid = 1'b1;
            else case (mode)
                0:       valid = 1'b1;
                1:       valid = cyc[0];
                default: valid = 1'($urandom_range(0, 1));
            endcase
            if (bi >= stim_q.size()) valid = 1'b0;
            bus.byte_valid = valid;
            bus.byte_data  = (bi < stim_q.size()) ? stim_q[bi] : 8'($urandom);
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_after_start", bus.busy, 1'b1);
                check("ready_first_cycle", bus.byte_ready, (n > 0));
                check("error_cleared", bus.error, 1'b0);
            end
            if (bus.mem_we) begin
                got_addr.push_back(bus.mem_addr);
                got_data.push_back(bus.mem_wd);
                if (bus.byte_ready) overlap++;
            end
            if (valid && bus.byte_ready) begin
                bi++; hs++; pending = 0;
            end else begin
                pending = valid;
            end
            if (bus.done) begin done_cyc = cyc; break; end
            if (bus.error) begin err_seen = 1; break; end
        end

        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        @(negedge clk);
        check("idle_after_run", bus.busy, 1'b0);
        check("done_one_cycle", bus.done, 1'b0);

        check("done_seen", (done_cyc >= 0), !expect_fail);
        check("error_flag", bus.error, expect_fail);
        if (expect_fail) check("err_addr", bus.err_addr, fail_addr);
        if (!expect_fail && mode == 0) check("done_cycle", done_cyc, 1 + CYC_PER_WORD * n);
        check("write_count", got_addr.size(), n_exp);
        check("bytes_taken", hs, n_exp * BYTES);
        check("we_with_ready", overlap, 0);
        for (int k = 0; k < n_exp && k < got_addr.size(); k++) begin
            check($sformatf("wr%0d_addr", k), got_addr[k], exp_addr[k]);
            check($sformatf("wr%0d_data", k), got_data[k], exp_data[k]);
            check($sformatf("mem%0d", k), mem[exp_addr[k]], exp_data[k]);
        end
    endtask

    initial begin
        logic [AW-1:0] rb;
        int            we_before;

        bus.start = 1'b0; bus.base_addr = '0; bus.word_cnt = '0;
        bus.byte_valid = 1'b0; bus.byte_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_byte_ready", bus.byte_ready, 1'b0);
        check("rst_mem_we",     bus.mem_we,     1'b0);
        check("rst_mem_addr",   bus.mem_addr,   '0);
        check("rst_mem_wd",     bus.mem_wd,     '0);
        check("rst_busy",       bus.busy,       1'b0);
        check("rst_done",       bus.done,       1'b0);
        check("rst_error",      bus.error,      1'b0);
        check("rst_err_addr",   bus.err_addr,   '0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Zero-length run: done next cycle, no write
        stim_q.delete();
        run_prog(16'h0000, 0, 0, 0, '0);

        // Directed two-word run
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_prog(16'h0010, 2, 0, 0, '0);

        // Stalled stream, same bytes
        run_prog(16'h0030, 2, 1, 0, '0);

        // Address wrap
        stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        run_prog(16'hFFFF, 2, 0, 0, '0);

`ifdef NVM_PROG_VERIFY_EN
        // Read-back mismatch at 0x0021, then a fresh start clears error
        stim_q.delete();
        for (int i = 0; i < 3 * BYTES; i++) stim_q.push_back(8'($urandom));
        corrupt_en = 1'b1; corrupt_addr = 16'h0021;
        run_prog(16'h0020, 3, 0, 1, 16'h0021);
        corrupt_en = 1'b0;
        stim_q.delete();
        run_prog(16'h0100, 0, 0, 0, '0);
`endif

        // Reset after 2 of 4 bytes: nothing written, next run starts from byte 0
        we_before = we_cycles;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 16'h0040; bus.word_cnt = 16'd1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.byte_valid = 1'b1; bus.byte_data = 8'hA1;
        @(posedge clk); #1;
        bus.byte_data = 8'hA2;
        @(posedge clk); #1;
        bus.byte_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy",   bus.busy,     1'b0);
        check("midrst_wd",     bus.mem_wd,   '0);
        check("midrst_addr",   bus.mem_addr, '0);
        check("midrst_no_we",  we_cycles - we_before, 0);
        stim_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        run_prog(16'h0050, 1, 0, 0, '0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            int n, mode;
            n    = $urandom_range(1, 4);
            mode = $urandom_range(0, 2);
            rb   = (r % 3 == 0) ? 16'hFFFE : AW'($urandom_range(16'h0200, 16'hF000));
            stim_q.delete();
            for (int i = 0; i < n * BYTES; i++) stim_q.push_back(8'($urandom));
            run_prog(rb, n, mode, 0, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
